t05_code_packer: RTL and testbench

T05_CODE_PACKER -- requirements
Module: t05_code_packer

---
 rtl/t05_pkg.sv | 17 +
 rtl/t05_bit_accum.sv | 53 +++++
 rtl/t05_code_packer.sv | 188 ++++++++++++++++++
 tb/tb_t05_code_packer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/t05_pkg.sv
// Shared definitions for the code packer: default sizes and the control FSM state type.
package t05_pkg;

  localparam int unsigned DefMaxLen = 128;
  localparam int unsigned DefOutW   = 8;
  localparam int unsigned DefCntW   = 32;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StShift,
    StEmit,
    StFlush,
    StError
  } state_e;

endpackage

// File: rtl/t05_bit_accum.sv
// Bit accumulator: shifts bits in MSB-first, tracks fill level and produces a
// left-justified, zero-padded view of a partial word.
module t05_bit_accum #(
  parameter int unsigned OUT_W = 8,
  localparam int unsigned PadW  = $clog2(OUT_W),
  localparam int unsigned FillW = $clog2(OUT_W + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             shift_i,
  input  logic             bit_i,
  output logic [OUT_W-1:0] word_o,
  output logic [OUT_W-1:0] just_o,
  output logic [PadW-1:0]  pad_o,
  output logic             full_o,
  output logic             will_fill_o
);

  logic [OUT_W-1:0] acc_q, acc_d;
  logic [FillW-1:0] fill_q, fill_d;
  logic [FillW-1:0] pad_w;

  always_comb begin
    acc_d  = acc_q;
    fill_d = fill_q;
    if (clear_i) begin
      acc_d  = '0;
      fill_d = '0;
    end else if (shift_i) begin
      acc_d  = {acc_q[OUT_W-2:0], bit_i};
      fill_d = fill_q + FillW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q  <= '0;
      fill_q <= '0;
    end else begin
      acc_q  <= acc_d;
      fill_q <= fill_d;
    end
  end

  assign pad_w       = FillW'(OUT_W) - fill_q;
  assign pad_o       = PadW'(pad_w);
  assign just_o      = acc_q << pad_w;
  assign word_o      = acc_q;
  assign full_o      = (fill_q == FillW'(OUT_W));
  assign will_fill_o = (fill_q == FillW'(OUT_W - 1));

endmodule

// File: rtl/t05_code_packer.sv
// Packs variable-length codes (MSB-first) into OUT_W-bit words with a ready/valid
// output and a zero-padded final word.
module t05_code_packer
  import t05_pkg::*;
#(
  parameter int unsigned MAX_LEN = DefMaxLen,
  parameter int unsigned OUT_W   = DefOutW,
  parameter int unsigned CNT_W   = DefCntW,
  localparam int unsigned LEN_W  = $clog2(MAX_LEN + 1),
  localparam int unsigned PAD_W  = $clog2(OUT_W)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CNT_W-1:0]   totChar,
  input  logic               code_valid,
  input  logic [MAX_LEN-1:0] code,
  input  logic [LEN_W-1:0]   code_len,
  output logic               code_ready,
  output logic               out_valid,
  output logic [OUT_W-1:0]   out_data,
  output logic               out_last,
  output logic [PAD_W-1:0]   out_pad,
  input  logic               out_ready,
  output logic               busy,
  output logic               done,
  output logic               err
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   tot_q, tot_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [MAX_LEN-1:0] code_q, code_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic               last_q, last_d;
  logic               err_q, err_d;
  logic               done_q, done_d;

  logic               acc_clear, acc_shift;
  logic [OUT_W-1:0]   acc_word, acc_just;
  logic [PAD_W-1:0]   acc_pad;
  logic               acc_full, acc_will_fill;

  t05_bit_accum #(
    .OUT_W (OUT_W)
  ) u_accum (
    .clk_i       (clk),
    .rst_i       (rst),
    .clear_i     (acc_clear),
    .shift_i     (acc_shift),
    .bit_i       (code_q[MAX_LEN-1]),
    .word_o      (acc_word),
    .just_o      (acc_just),
    .pad_o       (acc_pad),
    .full_o      (acc_full),
    .will_fill_o (acc_will_fill)
  );

  always_comb begin
    state_d   = state_q;
    tot_d     = tot_q;
    cnt_d     = cnt_q;
    code_d    = code_q;
    rem_d     = rem_q;
    last_d    = last_q;
    err_d     = err_q;
    done_d    = 1'b0;
    acc_clear = 1'b0;
    acc_shift = 1'b0;

    unique case (state_q)
      StIdle, StError: begin
        if (start) begin
          err_d     = 1'b0;
          tot_d     = totChar;
          cnt_d     = '0;
          last_d    = 1'b0;
          acc_clear = 1'b1;
          if (totChar != '0) begin
            state_d = StWait;
          end else begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      StWait: begin
        if (code_valid) begin
          if (code_len == '0 || code_len > LEN_W'(MAX_LEN)) begin
            err_d   = 1'b1;
            state_d = StError;
          end else begin
            // Left-justify so the next bit to send is always the MSB.
            code_d  = code << (LEN_W'(MAX_LEN) - code_len);
            rem_d   = code_len;
            state_d = StShift;
          end
        end
      end
      StShift: begin
        acc_shift = !acc_full;
        code_d    = code_q << 1;
        rem_d     = rem_q - LEN_W'(1);
        if (rem_q == LEN_W'(1)) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == tot_q) begin
            if (acc_will_fill) begin
              state_d = StEmit;
              last_d  = 1'b1;
            end else begin
              state_d = StFlush;
            end
          end else begin
            state_d = acc_will_fill ? StEmit : StWait;
          end
        end else if (acc_will_fill) begin
          state_d = StEmit;
        end
      end
      StEmit: begin
        if (out_ready) begin
          acc_clear = 1'b1;
          if (last_q) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else if (rem_q != '0) begin
            state_d = StShift;
          end else begin
            state_d = StWait;
          end
        end
      end
      StFlush: begin
        if (out_ready) begin
          acc_clear = 1'b1;
          state_d   = StIdle;
          done_d    = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      tot_q   <= '0;
      cnt_q   <= '0;
      code_q  <= '0;
      rem_q   <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tot_q   <= tot_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      rem_q   <= rem_d;
      last_q  <= last_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    out_pad   = '0;
    if (state_q == StEmit) begin
      out_valid = 1'b1;
      out_data  = acc_word;
      out_last  = last_q;
    end else if (state_q == StFlush) begin
      out_valid = 1'b1;
      out_data  = acc_just;
      out_last  = 1'b1;
      out_pad   = acc_pad;
    end
  end

  assign code_ready = (state_q == StWait);
  assign busy       = (state_q != StIdle) && (state_q != StError);
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_t05_code_packer.sv
// Randomized and directed bench for t05_code_packer against a bit-stream reference model.
module tb_t05_code_packer;

  localparam int MAX_LEN = 128;
  localparam int OUT_W   = 8;
  localparam int CNT_W   = 32;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);
  localparam int PAD_W   = $clog2(OUT_W);
  localparam int Bound   = 5000;

  logic               clk, rst, start, code_valid, out_ready;
  logic [CNT_W-1:0]   totChar;
  logic [MAX_LEN-1:0] code;
  logic [LEN_W-1:0]   code_len;
  logic               code_ready, out_valid, out_last, busy, done, err;
  logic [OUT_W-1:0]   out_data;
  logic [PAD_W-1:0]   out_pad;

  t05_code_packer #(
    .MAX_LEN (MAX_LEN),
    .OUT_W   (OUT_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .totChar    (totChar),
    .code_valid (code_valid),
    .code       (code),
    .code_len   (code_len),
    .code_ready (code_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_pad    (out_pad),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [MAX_LEN-1:0] q_code[$];
  int                 q_len[$];
  logic [OUT_W-1:0]   exp_data[$];
  logic               exp_last[$];
  int                 exp_pad[$];

  logic [OUT_W-1:0]   first_word, last_word;
  int                 last_pad, latency;

  // Reference: concatenate all code bits into one stream, cut into words, pad the tail.
  task automatic build_model();
    bit               bits[$];
    logic [OUT_W-1:0] w;
    int               n;
    exp_data.delete();
    exp_last.delete();
    exp_pad.delete();
    foreach (q_code[c])
      for (int i = q_len[c] - 1; i >= 0; i--) bits.push_back(q_code[c][i]);
    while (bits.size() > 0) begin
      w = '0;
      n = 0;
      while (n < OUT_W && bits.size() > 0) begin
        w = {w[OUT_W-2:0], bits.pop_front()};
        n++;
      end
      w = w << (OUT_W - n);
      exp_data.push_back(w);
      exp_pad.push_back(OUT_W - n);
      exp_last.push_back(bits.size() == 0);
    end
  endtask

  task automatic run_packet(input int stall, input int gap_pct);
    int               idx, wi, scnt, k, accept_k, valid_k, last_k;
    bit               fin;
    logic [OUT_W-1:0] held;
    build_model();
    idx = 0; wi = 0; scnt = 0; k = 0; fin = 0;
    accept_k = -1; valid_k = -1; last_k = -100;
    held = '0;
    start   = 1'b1;
    totChar = CNT_W'(q_code.size());
    step();
    start = 1'b0;
    while (!fin && k < Bound) begin
      if (done) begin
        fin = 1;
        check("done_timing", k, last_k + 1);
      end else begin
        code_valid = (idx < q_code.size()) && ($urandom_range(99) >= gap_pct);
        if (code_valid) begin
          code     = q_code[idx];
          code_len = LEN_W'(q_len[idx]);
        end
        if (code_valid && code_ready) begin
          if (idx == 0) accept_k = k;
          idx++;
        end
        out_ready = 1'b0;
        if (out_valid) begin
          if (valid_k < 0) valid_k = k;
          if (scnt < stall) begin
            if (scnt == 0) held = out_data;
            else check("stall_hold", out_data, held);
            scnt++;
          end else begin
            out_ready = 1'b1;
            if (stall > 0) check("stall_hold", out_data, held);
            if (wi < exp_data.size()) begin
              check("word_data", out_data, exp_data[wi]);
              check("word_last", out_last, exp_last[wi]);
              check("word_pad", out_pad, exp_pad[wi]);
            end else begin
              check("extra_word", 1'b1, 1'b0);
            end
            if (wi == 0) first_word = out_data;
            if (out_last) begin
              last_word = out_data;
              last_pad  = int'(out_pad);
              last_k    = k;
            end
            wi++;
            scnt = 0;
          end
        end
        step();
        k++;
      end
    end
    code_valid = 1'b0;
    out_ready  = 1'b0;
    latency    = valid_k - accept_k;
    check("run_done", fin, 1'b1);
    check("word_count", wi, exp_data.size());
    check("busy_end", busy, 1'b0);
    step();
    check("done_single", done, 1'b0);
  endtask

  function automatic logic [16:0] all_outs();
    return {code_ready, out_valid, out_data, out_last, out_pad, busy, done, err};
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; totChar = '0; code_valid = 1'b0;
    code = '0; code_len = '0; out_ready = 1'b0;
    step();
    step();
    check("reset_outs", all_outs(), '0);
    rst = 1'b0;
    step();

    // Two 4-bit codes fill exactly one word.
    q_code = '{128'hA, 128'h6};
    q_len  = '{4, 4};
    run_packet(0, 0);
    check("a6_word", first_word, 8'hA6);
    check("a6_pad", last_pad, 0);

    // Short code flushed with padding.
    q_code = '{128'h5};
    q_len  = '{3};
    run_packet(0, 0);
    check("a0_word", last_word, 8'hA0);
    check("a0_pad", last_pad, 5);

    // 12-bit code spans two words; first word after OUT_W+1 cycles.
    q_code = '{128'hABC};
    q_len  = '{12};
    run_packet(0, 0);
    check("abc_first", first_word, 8'hAB);
    check("abc_last", last_word, 8'hC0);
    check("abc_pad", last_pad, 4);
    check("abc_latency", latency, OUT_W + 1);

    // Same stream with the sink stalling 5 cycles on each word.
    run_packet(5, 0);
    check("stall_first", first_word, 8'hAB);
    check("stall_last", last_word, 8'hC0);

    // Illegal lengths: zero, then one past the maximum.
    start = 1'b1; totChar = 1; step(); start = 1'b0;
    check("err_wait_ready", code_ready, 1'b1);
    code_valid = 1'b1; code = 128'hFF; code_len = '0;
    step();
    code_valid = 1'b0;
    check("err_len0", {err, busy, code_ready}, 3'b100);
    for (int i = 0; i < 5; i++) begin
      check("err_no_word", out_valid, 1'b0);
      step();
    end
    start = 1'b1; totChar = 1; step(); start = 1'b0;
    check("err_cleared", {err, code_ready}, 2'b01);
    code_valid = 1'b1; code_len = LEN_W'(129);
    step();
    code_valid = 1'b0;
    check("err_len129", {err, busy, out_valid}, 3'b100);
    step();
    check("err_sticky", err, 1'b1);
    start = 1'b1; totChar = 0; step(); start = 1'b0;
    check("err_restart", {err, done}, 2'b01);
    step();

    // Reset in the middle of shifting a 128-bit code.
    start = 1'b1; totChar = 1; step(); start = 1'b0;
    out_ready  = 1'b1;
    code_valid = 1'b1;
    code       = {$urandom, $urandom, $urandom, $urandom};
    code_len   = LEN_W'(128);
    step();
    code_valid = 1'b0;
    step(); step(); step();
    check("mid_shift_busy", {busy, out_valid}, 2'b10);
    rst = 1'b1;
    step();
    rst = 1'b0;
    out_ready = 1'b0;
    check("rst_mid_run", all_outs(), '0);
    start = 1'b1; totChar = 0; step(); start = 1'b0;
    check("zero_run_done", {done, out_valid, busy}, 3'b100);
    step();
    check("zero_run_after", {done, out_valid}, 2'b00);

    // Randomized runs.
    for (int r = 0; r < 40; r++) begin
      int n;
      n = $urandom_range(1, 5);
      q_code.delete();
      q_len.delete();
      for (int c = 0; c < n; c++) begin
        q_code.push_back({$urandom, $urandom, $urandom, $urandom});
        if ($urandom_range(3) == 0) q_len.push_back($urandom_range(1, MAX_LEN));
        else q_len.push_back($urandom_range(1, 16));
      end
      run_packet($urandom_range(0, 2), $urandom_range(0, 40));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
